// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word/register-address types, EX/MEM stage
// state encoding and a saturating-increment helper.
package cpu_types_pkg;

    localparam int unsigned CPU_WORD_W = 32;
    localparam int unsigned CPU_REG_AW = 5;

    typedef logic [CPU_WORD_W-1:0] word_t;
    typedef logic [CPU_REG_AW-1:0] regbits_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } exmem_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic word_t sat_inc(input word_t v);
        return (v == '1) ? v : v + word_t'(1);
    endfunction

endpackage

// File: rtl/ex_mem_perf.sv
// EX/MEM performance counters: cycles spent waiting on memory and flushes
// actually applied. Both counters saturate. Only built with EX_MEM_PERF_EN.
module ex_mem_perf
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  logic  in_wait,
    input  logic  flush_apply,
    output word_t perf_wait_cyc,
    output word_t perf_flush_cnt
);

    // Saturating event counters, synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            perf_wait_cyc  <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (in_wait) begin
                perf_wait_cyc <= sat_inc(perf_wait_cyc);
            end
            if (flush_apply) begin
                perf_flush_cnt <= sat_inc(perf_flush_cnt);
            end
        end
    end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with a small memory-wait state machine.
// Holds the instruction while a load/store is outstanding, defers flushes
// that arrive mid-request, and produces forwarding data/qualifier.
// Optional feature: define EX_MEM_PERF_EN to add wait-cycle and flush
// counters (perf_wait_cyc, perf_flush_cnt).
module ex_mem_reg
    import cpu_types_pkg::*;
#(
    parameter int unsigned WORD_W = CPU_WORD_W,
    parameter int unsigned REG_AW = CPU_REG_AW
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ex_valid,
    input  logic              ex_rfWEN,
    input  logic              ex_dREN,
    input  logic              ex_dWEN,
    input  logic              ex_halt,
    input  logic [WORD_W-1:0] ex_aluout,
    input  logic [WORD_W-1:0] ex_rdat2,
    input  logic [WORD_W-1:0] ex_pc,
    input  logic [REG_AW-1:0] ex_dest,
    input  logic              advance,
    input  logic              flush,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    output logic              mem_valid,
    output logic              mem_rfWEN,
    output logic              mem_dREN,
    output logic              mem_dWEN,
    output logic              mem_halt,
    output logic [REG_AW-1:0] mem_dest,
    output logic [WORD_W-1:0] mem_aluout,
    output logic [WORD_W-1:0] mem_rdat2,
    output logic [WORD_W-1:0] mem_pc,
    output logic [WORD_W-1:0] mem_fwd_data,
    output logic              mem_fwd_ok,
    output logic              mem_busy
`ifdef EX_MEM_PERF_EN
    ,
    output word_t             perf_wait_cyc,
    output word_t             perf_flush_cnt
`endif
);

    exmem_state_t      state_q, state_n;
    logic              valid_q, valid_n;
    logic              rfwen_q, rfwen_n;
    logic              dren_q, dren_n;
    logic              dwen_q, dwen_n;
    logic              halt_q, halt_n;
    logic [REG_AW-1:0] dest_q, dest_n;
    logic [WORD_W-1:0] aluout_q, aluout_n;
    logic [WORD_W-1:0] rdat2_q, rdat2_n;
    logic [WORD_W-1:0] pc_q, pc_n;
    logic [WORD_W-1:0] load_q, load_n;
    logic              is_load_q, is_load_n;   // held instruction is a valid load
    logic              pend_q, pend_n;         // flush deferred until request completes
    logic              flush_apply_c;

    // State and pipeline registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            rfwen_q   <= 1'b0;
            dren_q    <= 1'b0;
            dwen_q    <= 1'b0;
            halt_q    <= 1'b0;
            dest_q    <= '0;
            aluout_q  <= '0;
            rdat2_q   <= '0;
            pc_q      <= '0;
            load_q    <= '0;
            is_load_q <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            valid_q   <= valid_n;
            rfwen_q   <= rfwen_n;
            dren_q    <= dren_n;
            dwen_q    <= dwen_n;
            halt_q    <= halt_n;
            dest_q    <= dest_n;
            aluout_q  <= aluout_n;
            rdat2_q   <= rdat2_n;
            pc_q      <= pc_n;
            load_q    <= load_n;
            is_load_q <= is_load_n;
            pend_q    <= pend_n;
        end
    end

    // Next-state: capture, bubble insertion, memory completion. A halted
    // stage ignores new captures and flushes; only an outstanding request
    // may still complete. Halt stays set through a deferred bubble.
    always_comb begin
        state_n       = state_q;
        valid_n       = valid_q;
        rfwen_n       = rfwen_q;
        dren_n        = dren_q;
        dwen_n        = dwen_q;
        halt_n        = halt_q;
        dest_n        = dest_q;
        aluout_n      = aluout_q;
        rdat2_n       = rdat2_q;
        pc_n          = pc_q;
        load_n        = load_q;
        is_load_n     = is_load_q;
        pend_n        = pend_q;
        flush_apply_c = 1'b0;

        case (state_q)
            WAIT: begin
                if (flush) begin
                    pend_n = 1'b1;
                end
                if (dhit) begin
                    if (dren_q) begin
                        load_n = dmemload;
                    end
                    dren_n  = 1'b0;
                    dwen_n  = 1'b0;
                    state_n = DONE;
                    if (pend_q || flush) begin
                        valid_n       = 1'b0;
                        rfwen_n       = 1'b0;
                        dest_n        = '0;
                        is_load_n     = 1'b0;
                        pend_n        = 1'b0;
                        flush_apply_c = 1'b1;
                    end
                end
            end
            default: begin
                if (!halt_q) begin
                    if (flush) begin
                        state_n       = IDLE;
                        valid_n       = 1'b0;
                        rfwen_n       = 1'b0;
                        dren_n        = 1'b0;
                        dwen_n        = 1'b0;
                        halt_n        = 1'b0;
                        dest_n        = '0;
                        is_load_n     = 1'b0;
                        flush_apply_c = 1'b1;
                    end else if (advance) begin
                        valid_n   = ex_valid;
                        rfwen_n   = ex_rfWEN;
                        dren_n    = ex_dREN;
                        dwen_n    = ex_dWEN;
                        halt_n    = ex_valid & ex_halt;
                        dest_n    = ex_rfWEN ? ex_dest : '0;
                        aluout_n  = ex_aluout;
                        rdat2_n   = ex_rdat2;
                        pc_n      = ex_pc;
                        is_load_n = ex_valid & ex_dREN;
                        state_n   = (ex_valid && (ex_dREN || ex_dWEN)) ? WAIT : IDLE;
                    end
                end
            end
        endcase
    end

    // Stage outputs; forwarding view is decoded from the held state.
    assign mem_valid    = valid_q;
    assign mem_rfWEN    = rfwen_q;
    assign mem_dREN     = dren_q;
    assign mem_dWEN     = dwen_q;
    assign mem_halt     = halt_q;
    assign mem_dest     = dest_q;
    assign mem_aluout   = aluout_q;
    assign mem_rdat2    = rdat2_q;
    assign mem_pc       = pc_q;
    assign mem_busy     = (state_q == WAIT);
    assign mem_fwd_data = (state_q == DONE && is_load_q) ? load_q : aluout_q;
    assign mem_fwd_ok   = (state_q == WAIT && is_load_q) ? 1'b0 : (rfwen_q & valid_q);

`ifdef EX_MEM_PERF_EN
    // Wait-cycle and applied-flush counters.
    ex_mem_perf u_perf (
        .CLK           (CLK),
        .RST           (RST),
        .in_wait       (state_q == WAIT),
        .flush_apply   (flush_apply_c),
        .perf_wait_cyc (perf_wait_cyc),
        .perf_flush_cnt(perf_flush_cnt)
    );
`else
    logic unused_flush_apply;
    assign unused_flush_apply = flush_apply_c;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Scoreboard bench for ex_mem_reg: the driver pushes a hand-computed output
// snapshot tagged with the cycle it must appear; the monitor pops and
// compares on each falling edge.
module tb_ex_mem_reg;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ex_valid, ex_rfWEN, ex_dREN, ex_dWEN, ex_halt;
    logic [31:0] ex_aluout, ex_rdat2, ex_pc;
    logic [4:0]  ex_dest;
    logic        advance, flush, dhit;
    logic [31:0] dmemload;
    logic        mem_valid, mem_rfWEN, mem_dREN, mem_dWEN, mem_halt;
    logic [4:0]  mem_dest;
    logic [31:0] mem_aluout, mem_rdat2, mem_pc, mem_fwd_data;
    logic        mem_fwd_ok, mem_busy;
`ifdef EX_MEM_PERF_EN
    logic [31:0] perf_wait_cyc, perf_flush_cnt;
`endif

    ex_mem_reg #(.WORD_W(32), .REG_AW(5)) dut (
        .CLK(CLK), .RST(RST),
        .ex_valid(ex_valid), .ex_rfWEN(ex_rfWEN), .ex_dREN(ex_dREN),
        .ex_dWEN(ex_dWEN), .ex_halt(ex_halt),
        .ex_aluout(ex_aluout), .ex_rdat2(ex_rdat2), .ex_pc(ex_pc), .ex_dest(ex_dest),
        .advance(advance), .flush(flush), .dhit(dhit), .dmemload(dmemload),
        .mem_valid(mem_valid), .mem_rfWEN(mem_rfWEN), .mem_dREN(mem_dREN),
        .mem_dWEN(mem_dWEN), .mem_halt(mem_halt), .mem_dest(mem_dest),
        .mem_aluout(mem_aluout), .mem_rdat2(mem_rdat2), .mem_pc(mem_pc),
        .mem_fwd_data(mem_fwd_data), .mem_fwd_ok(mem_fwd_ok), .mem_busy(mem_busy)
`ifdef EX_MEM_PERF_EN
        , .perf_wait_cyc(perf_wait_cyc), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        valid, rfwen, dren, dwen, halt, busy, fwd_ok;
        logic [4:0]  dest;
        logic [31:0] alu, rdat2, pc, fwd;
    } snap_t;

    int    cyc = 0;
    int    n_cmp = 0;
    int    n_err = 0;
    int    tag_q[$];
    snap_t exp_q[$];
    string name_q[$];

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: compare every expectation due at this cycle.
    always @(negedge CLK) begin
        snap_t act, e;
        int    t;
        string n;
        act.valid  = mem_valid;
        act.rfwen  = mem_rfWEN;
        act.dren   = mem_dREN;
        act.dwen   = mem_dWEN;
        act.halt   = mem_halt;
        act.busy   = mem_busy;
        act.fwd_ok = mem_fwd_ok;
        act.dest   = mem_dest;
        act.alu    = mem_aluout;
        act.rdat2  = mem_rdat2;
        act.pc     = mem_pc;
        act.fwd    = mem_fwd_data;
        while (tag_q.size() > 0 && tag_q[0] <= cyc) begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            n = name_q.pop_front();
            n_cmp++;
            if (t != cyc) begin
                n_err++;
                $display("FAIL %s: due at cycle %0d, reached at %0d", n, t, cyc);
            end else if (act !== e) begin
                n_err++;
                $display("FAIL %s: got v%b rf%b dr%b dw%b h%b busy%b ok%b dest%0d alu%h r2%h pc%h fwd%h, want v%b rf%b dr%b dw%b h%b busy%b ok%b dest%0d alu%h r2%h pc%h fwd%h",
                         n, act.valid, act.rfwen, act.dren, act.dwen, act.halt, act.busy,
                         act.fwd_ok, act.dest, act.alu, act.rdat2, act.pc, act.fwd,
                         e.valid, e.rfwen, e.dren, e.dwen, e.halt, e.busy,
                         e.fwd_ok, e.dest, e.alu, e.rdat2, e.pc, e.fwd);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_ex(input logic v, rf, dr, dw, h, input logic [4:0] d,
                          input logic [31:0] alu, r2, pc);
        ex_valid  = v;
        ex_rfWEN  = rf;
        ex_dREN   = dr;
        ex_dWEN   = dw;
        ex_halt   = h;
        ex_dest   = d;
        ex_aluout = alu;
        ex_rdat2  = r2;
        ex_pc     = pc;
    endtask

    // Push expected outputs after the next edge (f = valid,rfWEN,dREN,dWEN,halt), then clock.
    task automatic tick_expect(input string n, input logic [4:0] f, input logic busy, ok,
                               input logic [4:0] d, input logic [31:0] alu, r2, pc, fwd);
        snap_t e;
        e.valid  = f[4];
        e.rfwen  = f[3];
        e.dren   = f[2];
        e.dwen   = f[1];
        e.halt   = f[0];
        e.busy   = busy;
        e.fwd_ok = ok;
        e.dest   = d;
        e.alu    = alu;
        e.rdat2  = r2;
        e.pc     = pc;
        e.fwd    = fwd;
        tag_q.push_back(cyc + 1);
        exp_q.push_back(e);
        name_q.push_back(n);
        step();
    endtask

    initial begin
        RST = 1'b1;
        advance = 1'b0; flush = 1'b0; dhit = 1'b0; dmemload = 32'h0;
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
        step();
        tick_expect("reset", 5'b00000, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        RST = 1'b0;

        // Plain ALU op, then hold with advance low
        set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 32'hAA, 32'h11, 32'h100);
        advance = 1'b1;
        tick_expect("alu_op", 5'b11000, 1'b0, 1'b1, 5'd3, 32'hAA, 32'h11, 32'h100, 32'hAA);
        advance = 1'b0;
        set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 32'h55, 32'h11, 32'h100);
        tick_expect("alu_hold", 5'b11000, 1'b0, 1'b1, 5'd3, 32'hAA, 32'h11, 32'h100, 32'hAA);

        // No register write: dest forced to 0
        set_ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 32'h77, 32'h12, 32'h104);
        advance = 1'b1;
        tick_expect("norf_dest", 5'b10000, 1'b0, 1'b0, 5'd0, 32'h77, 32'h12, 32'h104, 32'h77);

        // Load with dhit three cycles late; advance stays high with a new op
        set_ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 32'h2000, 32'h13, 32'h108);
        tick_expect("load_wait0", 5'b11100, 1'b1, 1'b0, 5'd9, 32'h2000, 32'h13, 32'h108, 32'h2000);
        set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd10, 32'h999, 32'h14, 32'h10C);
        tick_expect("load_wait1", 5'b11100, 1'b1, 1'b0, 5'd9, 32'h2000, 32'h13, 32'h108, 32'h2000);
        tick_expect("load_wait2", 5'b11100, 1'b1, 1'b0, 5'd9, 32'h2000, 32'h13, 32'h108, 32'h2000);
        dhit = 1'b1; dmemload = 32'hDEAD_BEEF;
        tick_expect("load_done", 5'b11000, 1'b0, 1'b1, 5'd9, 32'h2000, 32'h13, 32'h108, 32'hDEAD_BEEF);
        dhit = 1'b0; dmemload = 32'h0; advance = 1'b0;
        tick_expect("load_done_hold", 5'b11000, 1'b0, 1'b1, 5'd9, 32'h2000, 32'h13, 32'h108, 32'hDEAD_BEEF);
        set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 32'h44, 32'h15, 32'h110);
        advance = 1'b1;
        tick_expect("done_to_idle", 5'b11000, 1'b0, 1'b1, 5'd4, 32'h44, 32'h15, 32'h110, 32'h44);

        // Store flushed while waiting: request held until dhit, then bubble
        set_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 32'h3000, 32'hCAFE, 32'h114);
        tick_expect("st_wait", 5'b11010, 1'b1, 1'b1, 5'd5, 32'h3000, 32'hCAFE, 32'h114, 32'h3000);
        advance = 1'b0; flush = 1'b1;
        tick_expect("st_flush_held", 5'b11010, 1'b1, 1'b1, 5'd5, 32'h3000, 32'hCAFE, 32'h114, 32'h3000);
        flush = 1'b0;
        tick_expect("st_pend", 5'b11010, 1'b1, 1'b1, 5'd5, 32'h3000, 32'hCAFE, 32'h114, 32'h3000);
        dhit = 1'b1;
        tick_expect("st_bubble", 5'b00000, 1'b0, 1'b0, 5'd0, 32'h3000, 32'hCAFE, 32'h114, 32'h3000);
        dhit = 1'b0;

        // advance and flush together in IDLE: bubble wins
        set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 32'h22, 32'h16, 32'h118);
        advance = 1'b1;
        tick_expect("idle_op", 5'b11000, 1'b0, 1'b1, 5'd2, 32'h22, 32'h16, 32'h118, 32'h22);
        set_ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd6, 32'h6000, 32'h17, 32'h11C);
        flush = 1'b1;
        tick_expect("adv_flush", 5'b00000, 1'b0, 1'b0, 5'd0, 32'h22, 32'h16, 32'h118, 32'h22);
        flush = 1'b0;

        // Sticky halt blocks captures; reset clears it
        set_ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 32'h18, 32'h120);
        tick_expect("halt_cap", 5'b10001, 1'b0, 1'b0, 5'd0, 32'h0, 32'h18, 32'h120, 32'h0);
        set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 32'h88, 32'h19, 32'h124);
        tick_expect("halt_hold0", 5'b10001, 1'b0, 1'b0, 5'd0, 32'h0, 32'h18, 32'h120, 32'h0);
        set_ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd8, 32'h89, 32'h19, 32'h124);
        tick_expect("halt_hold1", 5'b10001, 1'b0, 1'b0, 5'd0, 32'h0, 32'h18, 32'h120, 32'h0);
        RST = 1'b1; advance = 1'b0;
        tick_expect("halt_rst", 5'b00000, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        RST = 1'b0;

        // Reset while a load is outstanding abandons it
        set_ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 32'hAB0, 32'h1A, 32'h128);
        advance = 1'b1;
        tick_expect("rst_load_wait", 5'b11100, 1'b1, 1'b0, 5'd9, 32'hAB0, 32'h1A, 32'h128, 32'hAB0);
        RST = 1'b1; advance = 1'b0; dhit = 1'b1; dmemload = 32'h1234_5678;
        tick_expect("rst_mid_wait", 5'b00000, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        RST = 1'b0; dhit = 1'b0;
        set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 32'h1, 32'h1B, 32'h12C);
        advance = 1'b1;
        tick_expect("post_rst_op", 5'b11000, 1'b0, 1'b1, 5'd1, 32'h1, 32'h1B, 32'h12C, 32'h1);
        advance = 1'b0;

        step();
        step();
        if (tag_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0", tag_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ex_mem_reg.md
EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 SHALL have parameter WORD_W, default 32: datapath word width.
REQ-002 SHALL have parameter REG_AW, default 5: register-address width.
REQ-003 SHALL have ports `CLK` (in, 1, clock) and `RST` (in, 1, reset); one clock, reset synchronous and active-high.
REQ-004 SHALL have inputs `ex_valid`, `ex_rfWEN`, `ex_dREN`, `ex_dWEN`, `ex_halt` (in, 1 each): EX-stage qualifiers.
REQ-005 SHALL have inputs `ex_aluout`, `ex_rdat2`, `ex_pc` (in, WORD_W each) and `ex_dest` (in, REG_AW).
REQ-006 SHALL have inputs `advance` (in, 1: hazard unit permits capture), `flush` (in, 1: squash), `dhit` (in, 1: memory done) and `dmemload` (in, WORD_W).
REQ-007 SHALL have outputs `mem_valid`, `mem_rfWEN`, `mem_dREN`, `mem_dWEN`, `mem_halt` (out, 1 each), `mem_dest` (out, REG_AW), and `mem_aluout`, `mem_rdat2`, `mem_pc` (out, WORD_W each).
REQ-008 SHALL have outputs `mem_fwd_data` (out, WORD_W: value for forwarding), `mem_fwd_ok` (out, 1: `mem_fwd_data` usable) and `mem_busy` (out, 1: upstream must stall).

Function
REQ-009 SHALL keep a state machine with states IDLE, WAIT and DONE.
REQ-010 SHALL capture all `ex_*` fields on a rising edge when `advance` is 1 and `mem_busy` is 0; otherwise it holds all registers.
REQ-011 SHALL go from IDLE or DONE to WAIT on a capture with (`ex_dREN` or `ex_dWEN`) and `ex_valid`; any other capture goes to IDLE.
REQ-012 SHALL drive `mem_busy` = (state==WAIT), so a memory op with dhit at cycle k frees the stage at cycle k+1.
REQ-013 SHALL, in WAIT with `dhit` high, latch `dmemload` into an internal load register when `mem_dREN`, clear `mem_dREN`/`mem_dWEN`, and enter DONE.
REQ-014 SHALL drive `mem_fwd_data` = load register in DONE after a load, else `mem_aluout`.
REQ-015 SHALL drive `mem_fwd_ok` = 0 in WAIT when the held instruction is a load, otherwise `mem_rfWEN & mem_valid`.
REQ-016 SHALL, on `flush` with state not WAIT, load a bubble on the next edge: valid/rfWEN/dREN/dWEN/halt all 0, state IDLE. `flush` has priority over `advance`.
REQ-017 SHALL, on `flush` in WAIT, record a pending flush and keep the memory request; on entering DONE it applies the bubble and clears the pending bit.
REQ-018 SHALL make `mem_halt` sticky once a valid halt is captured, and suppress all further captures until reset.
REQ-019 SHALL force `mem_dest` to 0 whenever `mem_rfWEN` is 0, so forwarding never matches a bubble.

Reset
REQ-020 SHALL, with `RST` high at an edge, zero every output and the load register, set state IDLE, and clear the pending flush and halt; reset mid-WAIT abandons the request.

Configuration
REQ-021 SHALL, with EX_MEM_PERF_EN defined, add outputs `perf_wait_cyc` and `perf_flush_cnt` (32 bits each, saturating, reset 0), counting cycles in WAIT and applied flushes.
REQ-022 SHALL, without EX_MEM_PERF_EN, have neither port nor counter logic.

Structure
REQ-023 SHALL take `word_t`, `regbits_t` and the enum `exmem_state_t` {IDLE, WAIT, DONE} from the shared `cpu_types_pkg`.
REQ-024 SHALL place the counters in one sub-module, `ex_mem_perf`, instantiated only under EX_MEM_PERF_EN.

Verification
REQ-025 Plain ALU op: capture aluout=0x0000_00AA, dest=3, rfWEN=1 -> next cycle mem_fwd_data=0xAA, mem_fwd_ok=1, mem_busy=0.
REQ-026 Load with dhit 3 cycles late: mem_busy=1 for 3 cycles, mem_fwd_ok=0; dmemload=0xDEAD_BEEF -> DONE, mem_fwd_data=0xDEADBEEF, mem_busy=0.
REQ-027 Flush during WAIT of a store: mem_dWEN held until dhit; then mem_valid=0, mem_rfWEN=0, mem_dest=0.
REQ-028 advance and flush both high in IDLE -> bubble captured, ex fields ignored.
REQ-029 Halt captured, then advance with new valid ops -> mem_halt stays 1 and registers unchanged; RST then clears all outputs to 0.
